fp_result_fifo: RTL and testbench
=================================

# fp_result_fifo

Downstream buffer for the half-precision add/multiply core: it captures every result the core presents on its single-cycle `out_valid`/`out` strobe and holds it until a ready/valid consumer pops it. The core cannot be stalled, so this block absorbs bursts. It reports overflow by dropping and counting, never by back-pressuring. Optionally, each stored result is tagged with IEEE-754 binary16 class flags computed at write time.

## Interface
- `DEPTH`, 8, number of entries; power of two, minimum 2.
- `CNT_W`, 8, width of the drop counter.

- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: result strobe from the FP core (`out_valid`).
- `in_data` input 16: binary16 result from the FP core (`out`).
- `out_valid` output 1: head entry available; equals `!empty`.
- `out_ready` input 1: consumer accepts the head entry this cycle.
- `out_data` output 16: head entry data; 16'h0000 when empty.
- `out_flags` output 4: head entry class {nan, inf, sub, zero}; 4'h0 when empty. Present only with `FPR_CLASSIFY_EN`.
- `count` output $clog2(DEPTH)+1: number of stored entries.
- `full` output 1: count == DEPTH.
- `empty` output 1: count == 0.
- `drop_cnt` output CNT_W: saturating count of dropped results.
- `clr_drop` input 1: synchronous clear of `drop_cnt`.

## Operation
- Storage: circular array of DEPTH entries with write pointer, read pointer and occupancy count. Pointers wrap modulo DEPTH.
- Pop: occurs when `out_valid && out_ready`. The read pointer advances and count decrements.
- Push: occurs when `in_valid && (!full || pop)`. `in_data` is written at the write pointer, the pointer advances and count increments.
- Simultaneous push and pop:
  - When full: both happen and count stays DEPTH. No drop.
  - When empty: no pop occurs (`out_valid` is low), so only the push happens.
- Drop: `in_valid && full && !pop` discards `in_data`.
  - `drop_cnt` increments, saturating at all-ones.
  - Storage is unchanged.
- `clr_drop` has priority over a same-cycle drop: `drop_cnt` becomes 0 and that drop is not counted.
- `out_ready` while empty is ignored.
- Classification of the 16-bit word (exp = bits 14:10, man = bits 9:0):
  - zero: exp==0 and man==0.
  - sub: exp==0 and man!=0.
  - inf: exp==31 and man==0.
  - nan: exp==31 and man!=0.
  - normal: all flags 0.
  - The sign bit is ignored.
- Data is never modified: NaN payloads and the sign of zero pass through unchanged.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_flags`=0, `count`=0, `full`=0, `empty`=1, `drop_cnt`=0. Both pointers are 0.
- Reset mid-operation discards all entries and the drop count.
- Latency: a push at edge N makes the entry visible at the head after edge N. With no other entries, `out_valid` is high in cycle N+1. There is no same-cycle bypass from `in_data` to `out_data`.
- `out_data`/`out_flags` are stable while `out_valid && !out_ready`.
- Sustained throughput is one push and one pop per cycle.
- `count`, `full`, `empty` and `drop_cnt` are registered or derived only from registers. None depends combinationally on `in_valid` or `out_ready`.

## Configuration
- `FPR_CLASSIFY_EN` defined:
  - Each entry stores 20 bits: data plus flags computed from `in_data` at push.
  - `out_flags` port exists.
- `FPR_CLASSIFY_EN` undefined:
  - Entries are 16 bits.
  - No classifier logic.
  - `out_flags` port is absent.
- All other behaviour is identical in both builds.

## Structure
- Shared package `fp16_pkg`:
  - `fp16_t` packed struct {sign, exp[4:0], man[9:0]}.
  - Localparam `FP16_EXP_MAX` = 5'h1F.
  - `fp16_class_t` packed struct {nan, inf, sub, zero}.
  - The FP core reuses this package.
- Sub-module `fp16_classify`: combinational, `fp16_t` in, `fp16_class_t` out. Instantiated only under `FPR_CLASSIFY_EN`.

## Test plan
- Reset, then push 16'h3C00 with `out_ready`=0:
  - `out_valid`=1 and `out_data`=16'h3C00 on the next cycle.
  - `count`=1.
  - Flags 4'h0.
- Fill to DEPTH=8 with 16'h0001..16'h0008, then push 16'hAAAA with `out_ready`=0:
  - `full`=1, `drop_cnt`=1.
  - Draining yields 0001..0008 in order, then `empty`=1 and `out_data`=0.
- Full FIFO with same-cycle push of 16'h1234 and pop:
  - `count` stays 8, `drop_cnt` unchanged.
  - 16'h1234 emerges last.
- Classification build, push 16'h8000, 16'h0200, 16'h7C00, 16'h7E01, 16'hFC00:
  - Flags are zero, sub, inf, nan, inf.
  - Data is unchanged.
- Drive 300 drops with CNT_W=8:
  - `drop_cnt` saturates at 255.
  - `clr_drop` asserted together with a drop gives 0.
- Assert `rst` while 5 entries are stored:
  - Next cycle `count`=0, `empty`=1, `out_valid`=0.
  - A subsequent push reappears after 1 cycle.

Source files
------------

// File: rtl/fp16_pkg.sv
// fp16_pkg: binary16 field layout and class-flag types shared with the FP core
package fp16_pkg;
    localparam logic [4:0] FP16_EXP_MAX = 5'h1F;
    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] man;
    } fp16_t;
    typedef struct packed {
        logic nan;
        logic inf;
        logic sub;
        logic zero;
    } fp16_class_t;
endpackage

// File: rtl/fp_result_fifo_if.sv
// fp_result_fifo_if: core-to-FIFO strobe and FIFO-to-consumer ready/valid bundle; out_flags only with FPR_CLASSIFY_EN
interface fp_result_fifo_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef FPR_CLASSIFY_EN
    logic [3:0]  out_flags;
    modport master (output in_valid, in_data, out_ready, input out_valid, out_data, out_flags);
    modport slave (input in_valid, in_data, out_ready, output out_valid, out_data, out_flags);
`else
    modport master (output in_valid, in_data, out_ready, input out_valid, out_data);
    modport slave (input in_valid, in_data, out_ready, output out_valid, out_data);
`endif
endinterface

// File: rtl/fp16_classify.sv
// fp16_classify: combinational binary16 class decode {nan, inf, sub, zero}, sign ignored
module fp16_classify
    import fp16_pkg::*;
(
    input  fp16_t       val,
    output fp16_class_t cls
);
    logic exp_min, exp_max, man_zero, unused_sign;
    assign exp_min = val.exp == 5'h00;
    assign exp_max = val.exp == FP16_EXP_MAX;
    assign man_zero = val.man == 10'h000;
    assign unused_sign = val.sign;
    assign cls.nan = exp_max && !man_zero;
    assign cls.inf = exp_max && man_zero;
    assign cls.sub = exp_min && !man_zero;
    assign cls.zero = exp_min && man_zero;
endmodule

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: non-stalling result buffer with drop counter; FPR_CLASSIFY_EN adds class flags per entry
module fp_result_fifo
    import fp16_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_result_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       drop_cnt,
    input  logic                   clr_drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
`ifdef FPR_CLASSIFY_EN
    localparam int EW = 20;
`else
    localparam int EW = 16;
`endif
    logic [EW-1:0] mem [DEPTH];
    logic [EW-1:0] wr_entry;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic pop, push, drop;
`ifdef FPR_CLASSIFY_EN
    fp16_t       in_word;
    fp16_class_t in_cls;
    assign in_word = bus.in_data;
    fp16_classify u_classify (.val(in_word), .cls(in_cls));
    assign wr_entry = {in_cls, bus.in_data};
    assign bus.out_flags = empty ? 4'h0 : mem[rd_ptr][19:16];
`else
    assign wr_entry = bus.in_data;
`endif
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign bus.out_valid = !empty;
    assign bus.out_data = empty ? 16'h0000 : mem[rd_ptr][15:0];
    assign pop = bus.out_valid && bus.out_ready;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign push = bus.in_valid && (!full || pop);
    assign drop = bus.in_valid && full && !pop;
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_entry;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            drop_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            drop_cnt <= clr_drop ? '0 : (drop && drop_cnt != '1) ? drop_cnt + 1'b1 : drop_cnt;
        end
    end
endmodule

// File: tb/tb_fp_result_fifo.sv
// tb_fp_result_fifo: table-driven directed checks plus reset, latency and drop-saturation sequences
module tb_fp_result_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr_drop = 1'b0;
    logic [3:0] count;
    logic full, empty;
    logic [7:0] drop_cnt;
    int checks = 0;
    int failures = 0;

    fp_result_fifo_if bus ();

    fp_result_fifo #(.DEPTH(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus), .count(count), .full(full),
        .empty(empty), .drop_cnt(drop_cnt), .clr_drop(clr_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [15:0] din;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  ef;
        int          ec;
        logic        efull;
        logic        eempty;
        int          edrop;
    } vec_t;

    vec_t vt [$];

    function automatic vec_t v(logic iv, logic [15:0] din, logic rdy, logic clr, logic ev,
                               logic [15:0] ed, logic [3:0] ef, int ec, logic efull,
                               logic eempty, int edrop);
        vec_t r;
        r.iv = iv; r.din = din; r.rdy = rdy; r.clr = clr; r.ev = ev; r.ed = ed; r.ef = ef;
        r.ec = ec; r.efull = efull; r.eempty = eempty; r.edrop = edrop;
        return r;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(logic iv, logic [15:0] d, logic rdy, logic clr);
        bus.in_valid = iv;
        bus.in_data = d;
        bus.out_ready = rdy;
        clr_drop = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_state(string tag, int idx, logic ev, logic [15:0] ed, logic [3:0] ef,
                             int ec, logic efull, logic eempty, int edrop);
        chk({tag, ".out_valid"}, idx, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".out_data"}, idx, 32'(bus.out_data), 32'(ed));
`ifdef FPR_CLASSIFY_EN
        chk({tag, ".out_flags"}, idx, 32'(bus.out_flags), 32'(ef));
`endif
        chk({tag, ".count"}, idx, 32'(count), ec);
        chk({tag, ".full"}, idx, 32'(full), 32'(efull));
        chk({tag, ".empty"}, idx, 32'(empty), 32'(eempty));
        chk({tag, ".drop_cnt"}, idx, 32'(drop_cnt), edrop);
    endtask

    initial begin
        // flags: sub=4'h2 for 0001..0008, zero=1, inf=4, nan=8
        vt.push_back(v(1, 16'h3C00, 0, 0, 1, 16'h3C00, 4'h0, 1, 0, 0, 0));
        vt.push_back(v(0, 16'h0000, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 1, 0));
        for (int k = 1; k <= 8; k++)
            vt.push_back(v(1, 16'(k), 0, 0, 1, 16'h0001, 4'h2, k, k == 8, 0, 0));
        vt.push_back(v(1, 16'hAAAA, 0, 0, 1, 16'h0001, 4'h2, 8, 1, 0, 1));
        vt.push_back(v(1, 16'h1234, 1, 0, 1, 16'h0002, 4'h2, 8, 1, 0, 1));
        for (int k = 3; k <= 8; k++)
            vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'(k), 4'h2, 10 - k, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'h1234, 4'h0, 1, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 1, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 1, 1));
        vt.push_back(v(1, 16'h8000, 1, 0, 1, 16'h8000, 4'h1, 1, 0, 0, 1));
        vt.push_back(v(1, 16'h0200, 0, 0, 1, 16'h8000, 4'h1, 2, 0, 0, 1));
        vt.push_back(v(1, 16'h7C00, 0, 0, 1, 16'h8000, 4'h1, 3, 0, 0, 1));
        vt.push_back(v(1, 16'h7E01, 0, 0, 1, 16'h8000, 4'h1, 4, 0, 0, 1));
        vt.push_back(v(1, 16'hFC00, 0, 0, 1, 16'h8000, 4'h1, 5, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'h0200, 4'h2, 4, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'h7C00, 4'h4, 3, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'h7E01, 4'h8, 2, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 1, 16'hFC00, 4'h4, 1, 0, 0, 1));
        vt.push_back(v(0, 16'h0000, 1, 0, 0, 16'h0000, 4'h0, 0, 0, 1, 1));

        drive(0, 16'h0000, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        chk_state("reset", 0, 0, 16'h0000, 4'h0, 0, 0, 1, 0);
        rst = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].iv, vt[i].din, vt[i].rdy, vt[i].clr);
            tick();
            chk_state("vec", i, vt[i].ev, vt[i].ed, vt[i].ef, vt[i].ec, vt[i].efull,
                      vt[i].eempty, vt[i].edrop);
        end

        for (int k = 0; k < 5; k++) begin
            drive(1, 16'h0100 + 16'(k), 0, 0);
            tick();
        end
        chk("pre_rst.count", 0, 32'(count), 5);
        drive(0, 16'h0000, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_state("mid_rst", 0, 0, 16'h0000, 4'h0, 0, 0, 1, 0);
        drive(1, 16'h5555, 0, 0);
        #1;
        chk("no_bypass.out_valid", 0, 32'(bus.out_valid), 0);
        chk("no_bypass.out_data", 0, 32'(bus.out_data), 0);
        tick();
        chk_state("post_rst_push", 0, 1, 16'h5555, 4'h0, 1, 0, 0, 0);

        for (int k = 0; k < 7; k++) begin
            drive(1, 16'h7C00, 0, 0);
            tick();
        end
        chk("fill.full", 0, 32'(full), 1);
        for (int k = 0; k < 254; k++) begin
            drive(1, 16'hAAAA, 0, 0);
            tick();
        end
        chk("drop254", 0, 32'(drop_cnt), 254);
        for (int k = 0; k < 46; k++) begin
            drive(1, 16'hAAAA, 0, 0);
            tick();
        end
        chk_state("drop_sat", 0, 1, 16'h5555, 4'h0, 8, 1, 0, 255);
        drive(1, 16'hAAAA, 0, 1);
        tick();
        chk("clr_with_drop", 0, 32'(drop_cnt), 0);
        drive(1, 16'hAAAA, 0, 0);
        tick();
        chk("drop_after_clr", 0, 32'(drop_cnt), 1);
        drive(0, 16'h0000, 1, 0);
        tick();
        chk_state("pop_after_drops", 0, 1, 16'h7C00, 4'h4, 7, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
